// File: rtl/shreg_sched.sv
// shreg_sched: arbitrates two requesters round-robin, serially loads the
// accepted word into an external shift register (MSB first), reads the
// register back and presents the read-back word with a mismatch flag.
module shreg_sched #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             a_valid,
   input  logic [WIDTH-1:0] a_data,
   output logic             a_ready,
   input  logic             b_valid,
   input  logic [WIDTH-1:0] b_data,
   output logic             b_ready,
   output logic             sr_d,
   output logic             sr_en,
   output logic             sr_set,
   output logic             sr_reset,
   input  logic [WIDTH-1:0] sr_q,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   output logic             out_src,
   output logic             out_err,
   input  logic             out_ready
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, CLEAR, SHIFT, DONE} state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] word_q;
   logic [WIDTH-1:0] data_q;
   logic             src_q;
   logic             err_q;
   logic             last_b;
   logic             first_q;
   logic             rst_q;
   logic             grant_a, grant_b;

   // Next-state decode, arbitration and register-drive outputs
   always_comb begin
      state_nxt = state;
      grant_a   = 1'b0;
      grant_b   = 1'b0;
      sr_en     = 1'b0;
      sr_d      = 1'b0;
      sr_reset  = rst_q;  // clear the attached register on the cycle after reset
      out_valid = 1'b0;
      case (state)
         IDLE: begin
            // no grants while the post-reset clear is still being driven
            if (!rst_q) begin
               if (a_valid && (!b_valid || last_b))
                  grant_a = 1'b1;
               else if (b_valid)
                  grant_b = 1'b1;
               if (grant_a || grant_b)
                  state_nxt = CLEAR;
            end
         end
         CLEAR: begin
            sr_reset  = 1'b1;
            state_nxt = SHIFT;
         end
         SHIFT: begin
            sr_en = 1'b1;
            sr_d  = word_q[cnt];
            if (cnt == '0)
               state_nxt = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign a_ready = grant_a;
   assign b_ready = grant_b;
   assign sr_set  = 1'b0;
   assign out_src = src_q;

   // The register only holds the full word once the last shift edge has
   // passed, so the first DONE cycle shows sr_q directly; later cycles show
   // the copy captured at the end of that first cycle.
   assign out_data = first_q ? sr_q : data_q;
   assign out_err  = first_q ? (sr_q != word_q) : err_q;

   // State, bit counter, word buffer, grant history and result capture
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         word_q  <= '0;
         data_q  <= '0;
         src_q   <= 1'b0;
         err_q   <= 1'b0;
         last_b  <= 1'b1;
         first_q <= 1'b0;
         rst_q   <= 1'b1;
      end else begin
         state   <= state_nxt;
         rst_q   <= 1'b0;
         first_q <= (state == SHIFT) && (cnt == '0);
         if (grant_a) begin
            word_q <= a_data;
            src_q  <= 1'b0;
            last_b <= 1'b0;
         end else if (grant_b) begin
            word_q <= b_data;
            src_q  <= 1'b1;
            last_b <= 1'b1;
         end
         if (state == CLEAR)
            cnt <= CW'(WIDTH - 1);
         else if ((state == SHIFT) && (cnt != '0))
            cnt <= cnt - 1'b1;
         if (first_q) begin
            data_q <= sr_q;
            err_q  <= (sr_q != word_q);
         end
      end
   end

endmodule

// File: tb/tb_shreg_sched.sv
// tb_shreg_sched: directed bench for shreg_sched with a behavioural model of
// the attached shift register and an optional stuck-at-zero read-back fault.
module tb_shreg_sched;

   logic       clk = 1'b0;
   logic       reset;
   logic       a_valid, b_valid;
   logic [3:0] a_data, b_data;
   logic       a_ready, b_ready;
   logic       sr_d, sr_en, sr_set, sr_reset;
   logic [3:0] sr_q;
   logic       out_valid, out_src, out_err, out_ready;
   logic [3:0] out_data;

   logic [3:0] model_q;
   logic       fault;

   int total = 0;
   int bad   = 0;

   shreg_sched #(.WIDTH(4)) dut (
      .clk(clk), .reset(reset),
      .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
      .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
      .sr_d(sr_d), .sr_en(sr_en), .sr_set(sr_set), .sr_reset(sr_reset),
      .sr_q(sr_q),
      .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
      .out_err(out_err), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   // Behavioural shift register: shifts left, new bit enters at the LSB
   always @(posedge clk) begin
      if (sr_reset)    model_q <= 4'b0000;
      else if (sr_set) model_q <= 4'b1111;
      else if (sr_en)  model_q <= {model_q[2:0], sr_d};
   end

   assign sr_q = fault ? 4'b0000 : model_q;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] word;
      reset = 1'b1; a_valid = 1'b1; b_valid = 1'b0; a_data = 4'b0101; b_data = 4'b0000;
      out_ready = 1'b0; fault = 1'b0;
      tick();
      tick();
      // reset state, with A requesting to show it is ignored
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_data", out_data, 4'b0000);
      chk("rst_out_src", out_src, 1'b0);
      chk("rst_out_err", out_err, 1'b0);
      chk("rst_a_ready", a_ready, 1'b0);
      chk("rst_b_ready", b_ready, 1'b0);
      chk("rst_sr_en", sr_en, 1'b0);
      chk("rst_sr_d", sr_d, 1'b0);
      chk("rst_sr_set", sr_set, 1'b0);
      chk("rst_sr_reset", sr_reset, 1'b1);
      a_valid = 1'b0; reset = 1'b0;
      tick();
      chk("post_rst_sr_reset", sr_reset, 1'b0);

      // single request from A: 1011
      word = 4'b1011;
      a_valid = 1'b1; a_data = word; out_ready = 1'b1; #1;
      chk("t1_a_ready", a_ready, 1'b1);
      chk("t1_b_ready", b_ready, 1'b0);
      tick();
      a_valid = 1'b0; a_data = 4'b0000; #1;
      chk("t1_clear_sr_reset", sr_reset, 1'b1);
      chk("t1_clear_sr_en", sr_en, 1'b0);
      chk("t1_clear_a_ready", a_ready, 1'b0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("t1_shift_sr_en", sr_en, 1'b1);
         chk("t1_shift_sr_d", sr_d, word[3-i]);
         chk("t1_shift_sr_reset", sr_reset, 1'b0);
         chk("t1_shift_out_valid", out_valid, 1'b0);
      end
      tick();
      chk("t1_done_out_valid", out_valid, 1'b1);
      chk("t1_done_out_data", out_data, 4'b1011);
      chk("t1_done_out_src", out_src, 1'b0);
      chk("t1_done_out_err", out_err, 1'b0);
      chk("t1_done_sr_en", sr_en, 1'b0);
      tick();
      chk("t1_one_cycle_valid", out_valid, 1'b0);

      // fresh reset so the first tie goes to A
      reset = 1'b1;
      tick();
      chk("r2_sr_reset", sr_reset, 1'b1);
      reset = 1'b0;
      tick();

      // tie and round-robin: A=0001, B=1000 both valid throughout
      a_valid = 1'b1; a_data = 4'b0001; b_valid = 1'b1; b_data = 4'b1000; #1;
      for (int k = 0; k < 3; k++) begin
         chk("t2_a_ready", a_ready, (k != 1));
         chk("t2_b_ready", b_ready, (k == 1));
         for (int j = 0; j < 6; j++) tick();
         chk("t2_out_valid", out_valid, 1'b1);
         chk("t2_out_src", out_src, (k == 1));
         chk("t2_out_data", out_data, (k == 1) ? 4'b1000 : 4'b0001);
         chk("t2_out_err", out_err, 1'b0);
         if (k == 2) begin
            a_valid = 1'b0; b_valid = 1'b0;
         end
         tick();
      end
      chk("t2_idle_out_valid", out_valid, 1'b0);

      // backpressure with A then both requesters waiting; data changes ignored
      a_valid = 1'b1; a_data = 4'b0110; out_ready = 1'b0; #1;
      chk("t3_a_ready", a_ready, 1'b1);
      tick();
      a_data = 4'b1111; b_valid = 1'b1; b_data = 4'b0011; #1;
      chk("t3_clear_a_ready", a_ready, 1'b0);
      chk("t3_clear_b_ready", b_ready, 1'b0);
      for (int j = 0; j < 5; j++) tick();
      for (int i = 0; i < 5; i++) begin
         chk("t3_hold_out_valid", out_valid, 1'b1);
         chk("t3_hold_out_data", out_data, 4'b0110);
         chk("t3_hold_out_src", out_src, 1'b0);
         chk("t3_hold_out_err", out_err, 1'b0);
         chk("t3_hold_a_ready", a_ready, 1'b0);
         chk("t3_hold_b_ready", b_ready, 1'b0);
         tick();
      end
      out_ready = 1'b1; #1;
      chk("t3_release_out_valid", out_valid, 1'b1);
      chk("t3_release_out_data", out_data, 4'b0110);
      tick();
      chk("t3_idle_out_valid", out_valid, 1'b0);
      chk("t3_idle_b_ready", b_ready, 1'b1);
      chk("t3_idle_a_ready", a_ready, 1'b0);
      a_valid = 1'b0; b_valid = 1'b0; #1;
      tick();

      // faulty register: read-back stuck at 0000 after loading 1111
      a_valid = 1'b1; a_data = 4'b1111; fault = 1'b1; #1;
      chk("t4_a_ready", a_ready, 1'b1);
      tick();
      a_valid = 1'b0;
      for (int j = 0; j < 5; j++) tick();
      chk("t4_out_valid", out_valid, 1'b1);
      chk("t4_out_err", out_err, 1'b1);
      chk("t4_out_data", out_data, 4'b0000);
      chk("t4_out_src", out_src, 1'b0);
      tick();
      fault = 1'b0;
      chk("t4_after_out_valid", out_valid, 1'b0);

      // reset on the second shift cycle of a B word
      b_valid = 1'b1; b_data = 4'b1010; #1;
      chk("t5_b_ready", b_ready, 1'b1);
      tick();
      b_valid = 1'b0;
      tick();
      tick();
      reset = 1'b1; #1;
      chk("t5_shift2_sr_en", sr_en, 1'b1);
      chk("t5_shift2_sr_d", sr_d, 1'b0);
      tick();
      chk("t5_abort_out_valid", out_valid, 1'b0);
      chk("t5_abort_sr_reset", sr_reset, 1'b1);
      chk("t5_abort_sr_en", sr_en, 1'b0);
      chk("t5_abort_out_data", out_data, 4'b0000);
      reset = 1'b0;
      tick();

      // idle with no requests: nothing driven, no late result
      for (int i = 0; i < 20; i++) begin
         chk("t6_idle_sr_en", sr_en, 1'b0);
         chk("t6_idle_sr_reset", sr_reset, 1'b0);
         chk("t6_idle_out_valid", out_valid, 1'b0);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
